// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Latency: registered outputs; AN/SEG/DP change in the first cycle of each new BLANK/DRIVE state.
// Backpressure: none; load_i is a 1-cycle request acknowledged by load_ack_o at the next frame boundary.
//
// Ports:
//   clk, rst_n      - single clock, synchronous active-low reset
//   digits_i        - 8 hex nibbles, nibble i drives digit i
//   enable_i, dp_i  - per-digit show / decimal-point masks
//   load_i          - stage digits_i/enable_i/dp_i; latest request wins
//   load_ack_o      - pulses when staged data is committed to the shadow registers
//   frame_o         - pulses in the cycle the digit index wraps 7->0
//   SEG, DP, AN     - active-low segment {g,f,e,d,c,b,a}, decimal point and anode pins
//   digit_idx_o     - digit currently owning the slot
// Optional build macro: SEG7_LZB_EN enables leading-zero blanking.
module seg7_scan_controller #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits_i,
  input  logic [7:0]  enable_i,
  input  logic [7:0]  dp_i,
  input  logic        load_i,
  output logic        load_ack_o,
  output logic        frame_o,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic [7:0]  AN,
  output logic [2:0]  digit_idx_o
);

  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic          wrap;

  logic [31:0] shadow_dig, stage_dig;
  logic [7:0]  shadow_en, stage_en;
  logic [7:0]  shadow_dp, stage_dp;
  logic        pending;

  logic [7:0]  lz_blank;
  logic [3:0]  nib;
  logic        show;
  logic [6:0]  seg_nxt;
  logic        dp_nxt;
  logic [7:0]  an_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic; counter restarts at every state change
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    wrap      = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
        end
      end
      DRIVE: begin
        if (cnt == DIGIT_LAST) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = idx + 3'd1;
          wrap      = (idx == 3'd7);
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef SEG7_LZB_EN
  // Digit i (i>0) is dark when it and every more-significant nibble are zero.
  always_comb begin
    logic run;
    run      = 1'b1;
    lz_blank = '0;
    for (int i = 7; i >= 0; i--) begin
      run         = run & (shadow_dig[4*i +: 4] == 4'h0);
      lz_blank[i] = run;
    end
    lz_blank[0] = 1'b0;
  end
`else
  assign lz_blank = '0;
`endif

  // Output values for the state being entered. idx only moves on DRIVE->BLANK,
  // so the current idx is the right digit whenever the next state is DRIVE.
  always_comb begin
    nib     = shadow_dig[{idx, 2'b00} +: 4];
    show    = (state_nxt == DRIVE) && shadow_en[idx] && !lz_blank[idx];
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    an_nxt  = 8'hFF;
    if (show) begin
      seg_nxt = hex7(nib);
      dp_nxt  = ~shadow_dp[idx];
      an_nxt  = ~(8'h01 << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      SEG <= 7'h7F;
      DP  <= 1'b1;
      AN  <= 8'hFF;
    end else begin
      SEG <= seg_nxt;
      DP  <= dp_nxt;
      AN  <= an_nxt;
    end
  end

  assign digit_idx_o = idx;

  // Load handshake. At a wrap the shadow takes the staging contents as they
  // were before this edge, so a load sampled on the wrap edge waits a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_dig <= '0;
      shadow_en  <= '0;
      shadow_dp  <= '0;
      stage_dig  <= '0;
      stage_en   <= '0;
      stage_dp   <= '0;
      pending    <= 1'b0;
      load_ack_o <= 1'b0;
      frame_o    <= 1'b0;
    end else begin
      frame_o    <= wrap;
      load_ack_o <= wrap & pending;
      if (wrap && pending) begin
        shadow_dig <= stage_dig;
        shadow_en  <= stage_en;
        shadow_dp  <= stage_dp;
      end
      if (load_i) begin
        stage_dig <= digits_i;
        stage_en  <= enable_i;
        stage_dp  <= dp_i;
      end
      pending <= load_i | (pending & ~wrap);
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
module tb_seg7_scan_controller;

  localparam int DC    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = DC + BC;
  localparam int FRAME = 8 * SLOT;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] digits_i;
  logic [7:0]  enable_i;
  logic [7:0]  dp_i;
  logic        load_i;
  logic        load_ack_o;
  logic        frame_o;
  logic [6:0]  SEG;
  logic        DP;
  logic [7:0]  AN;
  logic [2:0]  digit_idx_o;

  always #5 clk = ~clk;

  seg7_scan_controller #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .enable_i(enable_i),
    .dp_i(dp_i), .load_i(load_i), .load_ack_o(load_ack_o), .frame_o(frame_o),
    .SEG(SEG), .DP(DP), .AN(AN), .digit_idx_o(digit_idx_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: position within the frame is simply the number of
  // clock edges since reset modulo the frame length.
  int          k;
  logic [31:0] s_dig, t_dig;
  logic [7:0]  s_en, s_dp, t_en, t_dp;
  logic        pend;
  int          acks_seen;
  int          lit_cycles;
  int          lit_per_digit [8];

  function automatic logic lzb(input int i, input logic [31:0] d);
`ifdef SEG7_LZB_EN
    return (i != 0) && ((d >> (4 * i)) == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    logic        r, ld;
    logic [31:0] d;
    logic [7:0]  e, p8;
    int          p, idx;
    logic        show, exp_frame, exp_ack;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    r = rst_n; ld = load_i; d = digits_i; e = enable_i; p8 = dp_i;
    @(posedge clk);
    #1;
    exp_frame = 1'b0;
    exp_ack   = 1'b0;
    if (!r) begin
      k = 0;
      s_dig = '0; s_en = '0; s_dp = '0;
      t_dig = '0; t_en = '0; t_dp = '0;
      pend = 1'b0;
    end else begin
      k++;
      if (k % FRAME == 0) begin
        exp_frame = 1'b1;
        if (pend) begin
          s_dig = t_dig; s_en = t_en; s_dp = t_dp;
          pend = 1'b0;
          exp_ack = 1'b1;
        end
      end
      if (ld) begin
        t_dig = d; t_en = e; t_dp = p8;
        pend = 1'b1;
      end
    end
    p    = k % FRAME;
    idx  = p / SLOT;
    show = ((p % SLOT) >= BC) && s_en[idx] && !lzb(idx, s_dig);
    exp_an  = show ? ~(8'h01 << idx) : 8'hFF;
    exp_seg = show ? HEX_TAB[s_dig[idx*4 +: 4]] : 7'h7F;
    exp_dp  = show ? ~s_dp[idx] : 1'b1;
    check("frame", {31'd0, frame_o}, {31'd0, exp_frame});
    check("ack", {31'd0, load_ack_o}, {31'd0, exp_ack});
    check("an", {24'd0, AN}, {24'd0, exp_an});
    check("seg", {25'd0, SEG}, {25'd0, exp_seg});
    check("dp", {31'd0, DP}, {31'd0, exp_dp});
    check("idx", {29'd0, digit_idx_o}, idx);
    if (load_ack_o) acks_seen++;
    if (AN != 8'hFF) begin
      lit_cycles++;
      for (int i = 0; i < 8; i++) if (!AN[i]) lit_per_digit[i]++;
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p8);
    digits_i = d; enable_i = e; dp_i = p8; load_i = 1'b1;
    step();
    load_i = 1'b0;
    digits_i = $urandom;
  endtask

  task automatic run_to(input int target);
    for (int n = 0; n <= FRAME && (k % FRAME) != target; n++) step();
  endtask

  task automatic wait_frame(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!frame_o && cycles < 3 * FRAME);
    if (!frame_o) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_stats();
    acks_seen = 0;
    lit_cycles = 0;
    for (int i = 0; i < 8; i++) lit_per_digit[i] = 0;
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; load_i = 1'b0;
    digits_i = '0; enable_i = '0; dp_i = '0;
    k = 0; pend = 1'b0;
    s_dig = '0; s_en = '0; s_dp = '0; t_dig = '0; t_en = '0; t_dp = '0;
    clear_stats();

    // Reset state
    repeat (3) step();
    check("rst_an", {24'd0, AN}, 32'hFF);
    check("rst_seg", {25'd0, SEG}, 32'h7F);
    check("rst_dp", {31'd0, DP}, 32'd1);
    check("rst_idx", {29'd0, digit_idx_o}, 32'd0);
    rst_n = 1'b1;

    // Idle: first frame pulse one full frame after reset release, no ack
    wait_frame(cyc);
    check("first_frame_cycle", cyc, FRAME);
    check("idle_no_ack", acks_seen, 0);

    // Full enable, dp on digit 0
    do_load(32'h8765_4321, 8'hFF, 8'h01);
    wait_frame(cyc);
    check("ack_with_frame", {31'd0, load_ack_o}, 32'd1);
    step(); step();
    check("d0_an", {24'd0, AN}, 32'hFE);
    check("d0_seg", {25'd0, SEG}, 32'h79);
    check("d0_dp", {31'd0, DP}, 32'd0);
    run_to(3 * SLOT + BC);
    check("d3_an", {24'd0, AN}, 32'hF7);
    check("d3_seg", {25'd0, SEG}, 32'h19);

    // Upper four digits disabled
    do_load(32'hFFFF_3698, 8'h0F, 8'h00);
    wait_frame(cyc);
    clear_stats();
    for (int n = 0; n < FRAME; n++) step();
    check("half_en_lit", lit_cycles, 4 * DC);
    check("half_en_d7", lit_per_digit[7], 0);

    // Two loads in one frame: one ack, the later data shown
    wait_frame(cyc);
    clear_stats();
    do_load(32'h1111_1111, 8'hFF, 8'h00);
    step(); step();
    do_load(32'hABCD_EF01, 8'hFF, 8'hFF);
    for (int n = 0; n < 2 * FRAME; n++) step();
    check("double_load_acks", acks_seen, 1);

    // Load on the cycle before the wrap edge while another load is pending
    run_to(40);
    clear_stats();
    do_load(32'h2222_2222, 8'hAA, 8'h00);
    run_to(FRAME - 1);
    do_load(32'h3333_3333, 8'h55, 8'h00);
    check("coincident_ack_old", {31'd0, load_ack_o}, 32'd1);
    wait_frame(cyc);
    check("coincident_ack_new", {31'd0, load_ack_o}, 32'd1);

    // Reset during digit 5 DRIVE with a load pending
    run_to(4 * SLOT);
    do_load(32'h9999_9999, 8'hFF, 8'hFF);
    run_to(5 * SLOT + BC + 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_an", {24'd0, AN}, 32'hFF);
    check("mid_rst_idx", {29'd0, digit_idx_o}, 32'd0);
    clear_stats();
    for (int n = 0; n < 2 * FRAME; n++) step();
    check("rst_no_ack", acks_seen, 0);
    check("rst_shadow_dark", lit_cycles, 0);

    // Leading-zero patterns
    do_load(32'h0000_0030, 8'hFF, 8'h00);
    wait_frame(cyc);
    clear_stats();
    for (int n = 0; n < FRAME; n++) step();
`ifdef SEG7_LZB_EN
    check("lzb_d2_dark", lit_per_digit[2], 0);
    check("lzb_d1_lit", lit_per_digit[1], DC);
`else
    check("nolzb_all_lit", lit_cycles, 8 * DC);
`endif
    do_load(32'h0000_0000, 8'hFF, 8'h00);
    wait_frame(cyc);
    clear_stats();
    for (int n = 0; n < FRAME; n++) step();
`ifdef SEG7_LZB_EN
    check("lzb_zero_only_d0", lit_cycles, DC);
`else
    check("nolzb_zero_all", lit_cycles, 8 * DC);
`endif

    // Random traffic, including occasional resets
    for (int n = 0; n < 40 * FRAME; n++) begin
      digits_i = $urandom;
      enable_i = 8'($urandom);
      dp_i     = 8'($urandom);
      load_i   = ($urandom_range(0, 19) == 0);
      rst_n    = ($urandom_range(0, 1499) != 0);
      step();
    end
    rst_n = 1'b1;
    load_i = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
